mem_stage: RTL

//  Memory-access stage of the 5-stage RV32I pipeline, directly downstream of EX.

---
 rtl/mem_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory handshake, load/store lane formatting, MEM/WB register.
// One cycle to MEM/WB when ready arrives with the request; o_data_busy stalls upstream while waiting.
module mem_stage #(
    parameter logic [31:0] RST_INST = 32'h00000033,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vld,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_opsel,
    input  logic [31:0] i_res_ff,
    input  logic [31:0] i_rs2_rdata,
    input  logic [4:0]  i_rd_waddr,
    input  logic        i_rd_wen,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_nxt_pc,
    input  logic        i_break,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_data_busy,
    output logic        o_vld,
    output logic [4:0]  o_rd_waddr,
    output logic        o_rd_wen,
    output logic [31:0] o_rd_wdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc,
    output logic        o_break,
    output logic        o_misaligned,
    output logic        o_bus_err
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    typedef struct packed {
        logic        vld;
        logic [4:0]  waddr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] nxt_pc;
        logic        brk;
        logic        mis;
        logic        err;
    } wb_t;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    wb_t           wb_q, wb_d;

    logic        memop, misaligned, abort, busy;
    logic [1:0]  boff;
    logic [3:0]  st_mask;
    logic [31:0] lane, ld_data;

    assign boff  = i_res_ff[1:0];
    assign memop = i_vld & (i_mem_read | i_mem_write);

    always_comb begin
        misaligned = 1'b0;
        st_mask    = 4'b1111;
        o_dmem_wdata = i_rs2_rdata;
        case (i_opsel[1:0])
            2'b00: begin
                st_mask      = 4'b0001 << boff;
                o_dmem_wdata = {4{i_rs2_rdata[7:0]}};
            end
            2'b01: begin
                misaligned   = boff[0];
                st_mask      = 4'b0011 << boff;
                o_dmem_wdata = {2{i_rs2_rdata[15:0]}};
            end
            default: misaligned = |boff;
        endcase
    end

    // The WAIT state holds the request on its own: the upstream is frozen, so inputs are stable.
    assign o_dmem_req  = !i_rst & ((state_q == S_WAIT) | (memop & !misaligned));
    assign o_dmem_wen  = i_mem_write;
    assign o_dmem_addr = {i_res_ff[31:2], 2'b00};
    assign o_dmem_mask = o_dmem_req ? st_mask : 4'b0000;

    assign abort = (MAX_WAIT != 0) & (state_q == S_WAIT) & (cnt_q == CNT_LAST) & !i_dmem_ready;
    assign busy  = o_dmem_req & !i_dmem_ready & !abort;
    assign o_data_busy = busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (busy) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
        end else if (!busy) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Aligned accesses only reach WB, so the shifted word equals rdata for word loads.
    assign lane = i_dmem_rdata >> {boff, 3'b000};

    always_comb begin
        case (i_opsel)
            3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_data = {24'h000000, lane[7:0]};
            3'b101:  ld_data = {16'h0000, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

    always_comb begin
        wb_d.vld    = i_vld;
        wb_d.waddr  = i_rd_waddr;
        wb_d.wen    = i_vld & i_rd_wen & !(memop & misaligned) & !abort;
        wb_d.wdata  = i_mem_read ? ld_data : i_res_ff;
        wb_d.inst   = i_inst;
        wb_d.pc     = i_pc;
        wb_d.nxt_pc = i_nxt_pc;
        wb_d.brk    = i_break;
        wb_d.mis    = memop & misaligned;
        wb_d.err    = abort;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wb_q        <= '0;
            wb_q.inst   <= RST_INST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!busy) begin
                wb_q <= wb_d;
            end
        end
    end

    assign o_vld        = wb_q.vld;
    assign o_rd_waddr   = wb_q.waddr;
    assign o_rd_wen     = wb_q.wen;
    assign o_rd_wdata   = wb_q.wdata;
    assign o_inst       = wb_q.inst;
    assign o_pc         = wb_q.pc;
    assign o_nxt_pc     = wb_q.nxt_pc;
    assign o_break      = wb_q.brk;
    assign o_misaligned = wb_q.mis;
    assign o_bus_err    = wb_q.err;
endmodule
